// File: rtl/ysyx_22041211_ifu.sv
// Multi-cycle instruction fetch unit: latches the PC, issues one word read on a
// valid/ready request channel, and hands {pc, inst, fault} to the decoder.
module ysyx_22041211_ifu #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic                flush_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_LEN-1:0] mem_req_addr_o,
  input  logic                mem_rsp_valid_i,
  input  logic [DATA_LEN-1:0] mem_rsp_data_i,
  input  logic                mem_rsp_err_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [DATA_LEN-1:0] inst_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic                fault_o,
  output logic [31:0]         fetch_cnt_o,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid & ready are both high;
  // valid never depends on ready, and payload is held stable while valid waits.
  // The response channel has no ready: a response is only taken in WAIT.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic [DATA_LEN-1:0] inst_q, inst_d;
  logic                fault_q, fault_d;
  logic                drop_q, drop_d;
  logic [31:0]         cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fetch_en_i && !flush_i) begin
          pc_d = pc_i;
          // Misaligned PCs never reach memory; they surface as a faulted slot.
          if (pc_i[1:0] != 2'b00) begin
            inst_d  = '0;
            fault_d = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (flush_i) drop_d = 1'b1;
        if (mem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (flush_i) drop_d = 1'b1;
        if (mem_rsp_valid_i) begin
          if (drop_q || flush_i) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            inst_d  = mem_rsp_err_i ? '0 : mem_rsp_data_i;
            fault_d = mem_rsp_err_i;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (inst_ready_i) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_valid_o = (state_q == REQ);
  assign mem_req_addr_o  = pc_q;
  assign inst_valid_o    = (state_q == HOLD);
  assign inst_o          = inst_q;
  assign pc_o            = pc_q;
  assign fault_o         = fault_q;
  assign fetch_cnt_o     = cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Directed bench for ysyx_22041211_ifu: inputs change 1ns after the rising
// edge, outputs are checked in the same window.
module tb_ysyx_22041211_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i = '0;
  logic        mem_rsp_err_i = 1'b0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fault_o;
  logic [31:0] fetch_cnt_o;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt = '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  ysyx_22041211_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en_i      (fetch_en_i),
    .pc_i            (pc_i),
    .flush_i         (flush_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_err_i   (mem_rsp_err_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .fault_o         (fault_o),
    .fetch_cnt_o     (fetch_cnt_o),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    fetch_en_i      = 1'b0;
    flush_i         = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_err_i   = 1'b0;
    inst_ready_i    = 1'b0;
  endtask

  // Driver: from IDLE, run a fetch with ready memory up to the HOLD cycle.
  task automatic drive_fetch(input logic [31:0] pc, input logic [31:0] data, input logic err);
    fetch_en_i      = 1'b1;
    pc_i            = pc;
    mem_req_ready_i = 1'b1;
    cyc();
    fetch_en_i      = 1'b0;
    cyc();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = data;
    mem_rsp_err_i   = err;
    cyc();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_err_i   = 1'b0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b want 0", mem_req_valid_o); end
    checks++; if (mem_req_addr_o !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 0", mem_req_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %0b want 0", inst_valid_o); end
    checks++; if ({inst_o, pc_o, fault_o} !== 65'h0) begin errors++; $display("FAIL reset_payload: inst %h pc %h fault %0b want zeros", inst_o, pc_o, fault_o); end
    checks++; if (fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", fetch_cnt_o); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    fetch_en_i      = 1'b1;
    pc_i            = 32'h8000_0000;
    mem_req_ready_i = 1'b1;
    inst_ready_i    = 1'b1;
    cyc();
    fetch_en_i = 1'b0;
    checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL basic_req_valid: got %0b want 1", mem_req_valid_o); end
    checks++; if (mem_req_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL basic_req_addr: got %h want 80000000", mem_req_addr_o); end
    cyc();
    checks++; if (mem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL basic_wait: req %0b inst_valid %0b want 0 0", mem_req_valid_o, inst_valid_o); end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h0000_0413;
    cyc();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL basic_inst_valid: got %0b want 1", inst_valid_o); end
    checks++; if (inst_o !== 32'h0000_0413) begin errors++; $display("FAIL basic_inst: got %h want 00000413", inst_o); end
    checks++; if (pc_o !== 32'h8000_0000 || fault_o !== 1'b0) begin errors++; $display("FAIL basic_pc_fault: pc %h fault %0b want 80000000 0", pc_o, fault_o); end
    checks++; if (fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL basic_cnt_before: got %h want %h", fetch_cnt_o, exp_cnt); end
    cyc();
    exp_cnt++;
    inst_ready_i    = 1'b0;
    mem_req_ready_i = 1'b0;
    checks++; if (fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL basic_cnt_after: got %h want %h", fetch_cnt_o, exp_cnt); end
    checks++; if (inst_valid_o !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL basic_back_idle: valid %0b state %0d want 0 %0d", inst_valid_o, dbg_state, S_IDLE); end
  endtask

  task automatic test_req_stall();
    fetch_en_i   = 1'b1;
    pc_i         = 32'h8000_0010;
    inst_ready_i = 1'b1;
    cyc();
    fetch_en_i = 1'b0;
    pc_i       = 32'h8000_0014;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h8000_0010) begin errors++; $display("FAIL stall_req_hold%0d: valid %0b addr %h want 1 80000010", i, mem_req_valid_o, mem_req_addr_o); end
      if (i == 3) mem_req_ready_i = 1'b1;
      cyc();
    end
    mem_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL stall_rsp_wait%0d: req %0b inst_valid %0b want 0 0", i, mem_req_valid_o, inst_valid_o); end
      cyc();
    end
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h0040_0093;
    cyc();
    mem_rsp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0040_0093 || pc_o !== 32'h8000_0010) begin errors++; $display("FAIL stall_deliver: valid %0b inst %h pc %h want 1 00400093 80000010", inst_valid_o, inst_o, pc_o); end
    cyc();
    exp_cnt++;
    inst_ready_i = 1'b0;
    checks++; if (fetch_cnt_o !== exp_cnt || mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL stall_fire: cnt %h req %0b want %h 0", fetch_cnt_o, mem_req_valid_o, exp_cnt); end
  endtask

  task automatic test_hold_stall();
    drive_fetch(32'h8000_0020, 32'h0010_0093, 1'b0);
    pc_i = 32'h8000_0024;
    for (int i = 0; i < 6; i++) begin
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0010_0093 || pc_o !== 32'h8000_0020) begin errors++; $display("FAIL hold_stable%0d: valid %0b inst %h pc %h", i, inst_valid_o, inst_o, pc_o); end
      checks++; if (mem_req_valid_o !== 1'b0 || fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL hold_quiet%0d: req %0b cnt %h want 0 %h", i, mem_req_valid_o, fetch_cnt_o, exp_cnt); end
      cyc();
    end
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    exp_cnt++;
    checks++; if (fetch_cnt_o !== exp_cnt || inst_valid_o !== 1'b0) begin errors++; $display("FAIL hold_fire: cnt %h valid %0b want %h 0", fetch_cnt_o, inst_valid_o, exp_cnt); end
  endtask

  task automatic test_flush_wait();
    fetch_en_i      = 1'b1;
    pc_i            = 32'h8000_0040;
    mem_req_ready_i = 1'b1;
    inst_ready_i    = 1'b1;
    cyc();
    fetch_en_i = 1'b0;
    cyc();
    mem_req_ready_i = 1'b0;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    checks++; if (dbg_state !== S_WAIT || inst_valid_o !== 1'b0) begin errors++; $display("FAIL flushw_still_wait: state %0d valid %0b want %0d 0", dbg_state, inst_valid_o, S_WAIT); end
    cyc();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hDEAD_BEEF;
    cyc();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (inst_valid_o !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL flushw_dropped%0d: valid %0b state %0d want 0 %0d", i, inst_valid_o, dbg_state, S_IDLE); end
      cyc();
    end
    checks++; if (inst_o === 32'hDEAD_BEEF || fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL flushw_no_capture: inst %h cnt %h want not deadbeef, %h", inst_o, fetch_cnt_o, exp_cnt); end
    pc_i            = 32'h8000_0100;
    fetch_en_i      = 1'b1;
    mem_req_ready_i = 1'b1;
    cyc();
    fetch_en_i = 1'b0;
    checks++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL flushw_refetch_req: valid %0b addr %h want 1 80000100", mem_req_valid_o, mem_req_addr_o); end
    cyc();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h0000_0013;
    cyc();
    mem_rsp_valid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0013 || pc_o !== 32'h8000_0100) begin errors++; $display("FAIL flushw_refetch_inst: valid %0b inst %h pc %h want 1 00000013 80000100", inst_valid_o, inst_o, pc_o); end
    cyc();
    inst_ready_i = 1'b0;
    exp_cnt++;
    checks++; if (fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL flushw_refetch_cnt: got %h want %h", fetch_cnt_o, exp_cnt); end
  endtask

  task automatic test_flush_hold();
    drive_fetch(32'h8000_0200, 32'h0020_0113, 1'b0);
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL flushh_in_hold: valid %0b want 1", inst_valid_o); end
    flush_i      = 1'b1;
    inst_ready_i = 1'b1;
    cyc();
    flush_i      = 1'b0;
    inst_ready_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL flushh_idle: valid %0b state %0d want 0 %0d", inst_valid_o, dbg_state, S_IDLE); end
    checks++; if (fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL flushh_cnt: got %h want %h", fetch_cnt_o, exp_cnt); end
  endtask

  task automatic test_misaligned();
    fetch_en_i      = 1'b1;
    pc_i            = 32'h8000_0002;
    mem_req_ready_i = 1'b1;
    cyc();
    fetch_en_i = 1'b0;
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL misal_no_req: got %0b want 0", mem_req_valid_o); end
    checks++; if (inst_valid_o !== 1'b1 || fault_o !== 1'b1 || inst_o !== 32'h0) begin errors++; $display("FAIL misal_fault: valid %0b fault %0b inst %h want 1 1 0", inst_valid_o, fault_o, inst_o); end
    checks++; if (pc_o !== 32'h8000_0002) begin errors++; $display("FAIL misal_pc: got %h want 80000002", pc_o); end
    mem_req_ready_i = 1'b0;
    inst_ready_i    = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    exp_cnt++;
    checks++; if (fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL misal_cnt: got %h want %h", fetch_cnt_o, exp_cnt); end
  endtask

  task automatic test_bus_err();
    drive_fetch(32'h8000_0300, 32'h1234_5678, 1'b1);
    checks++; if (inst_valid_o !== 1'b1 || fault_o !== 1'b1 || inst_o !== 32'h0) begin errors++; $display("FAIL buserr: valid %0b fault %0b inst %h want 1 1 0", inst_valid_o, fault_o, inst_o); end
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    exp_cnt++;
    checks++; if (fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL buserr_cnt: got %h want %h", fetch_cnt_o, exp_cnt); end
    drive_fetch(32'h8000_0304, 32'h0000_0513, 1'b0);
    checks++; if (fault_o !== 1'b0 || inst_o !== 32'h0000_0513) begin errors++; $display("FAIL buserr_clear: fault %0b inst %h want 0 00000513", fault_o, inst_o); end
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset_mid();
    fetch_en_i      = 1'b1;
    pc_i            = 32'h8000_0400;
    mem_req_ready_i = 1'b1;
    cyc();
    fetch_en_i = 1'b0;
    cyc();
    mem_req_ready_i = 1'b0;
    checks++; if (dbg_state !== S_WAIT) begin errors++; $display("FAIL rstmid_in_wait: state %0d want %0d", dbg_state, S_WAIT); end
    rst = 1'b1;
    #1;
    checks++; if (dbg_state !== S_IDLE || mem_req_addr_o !== 32'h0 || fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL rstmid_async: state %0d addr %h cnt %h want 0 0 0", dbg_state, mem_req_addr_o, fetch_cnt_o); end
    exp_cnt = '0;
    cyc();
    rst = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hCAFE_BABE;
    cyc();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || pc_o !== 32'h0 || fault_o !== 1'b0) begin errors++; $display("FAIL rstmid_stale: valid %0b inst %h pc %h fault %0b want zeros", inst_valid_o, inst_o, pc_o, fault_o); end
    checks++; if (dbg_state !== S_IDLE || fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL rstmid_state: state %0d cnt %h want %0d %h", dbg_state, fetch_cnt_o, S_IDLE, exp_cnt); end
  endtask

  task automatic test_cnt_wrap();
    force dut.cnt_q = 32'hFFFF_FFFF;
    cyc();
    release dut.cnt_q;
    cyc();
    exp_cnt = 32'hFFFF_FFFF;
    checks++; if (fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", fetch_cnt_o); end
    drive_fetch(32'h8000_0500, 32'h0000_0073, 1'b0);
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    checks++; if (fetch_cnt_o !== exp_cnt) begin errors++; $display("FAIL wrap_fire: got %h want %h", fetch_cnt_o, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_hold_stall();
    test_flush_wait();
    test_flush_hold();
    test_misaligned();
    test_bus_err();
    test_reset_mid();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000ns");
    $fatal(1, "timeout");
  end

endmodule
